pipe_stall_ctrl: RTL and testbench

- Central pipeline sequencer for the 6-stage core (PC, IF, ID, EX, MEM, WB).
- Merges per-stage stall requests into the shared stall[5:0] vector consumed by every inter-stage register, including MEM/WB.
- Sequences exception flushes, holding the redirect until any outstanding instruction-bus fetch has drained.
- Supplies the redirect PC to the PC stage.

---
 rtl/pipe_stall_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: merges per-stage stall requests, sequences exception flushes
// behind instruction-bus drain, and supplies the redirect PC. Optional counters: PIPE_PERF_CNT_EN.
module pipe_stall_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DRAIN_MAX = 64,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              excp_valid,
  input  logic [ADDR_W-1:0] excp_pc,
  input  logic              ibus_busy,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [ADDR_W-1:0] flush_pc,
  output logic              drain_timeout,
  output logic [CNT_W-1:0]  perf_stall_if,
  output logic [CNT_W-1:0]  perf_stall_id,
  output logic [CNT_W-1:0]  perf_stall_ex,
  output logic [CNT_W-1:0]  perf_stall_mem,
  output logic [CNT_W-1:0]  perf_flush
);

  localparam int DW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DW-1:0]     r_drain_cnt;
  logic [ADDR_W-1:0] r_flush_pc;
  logic              w_accept;

  // Request vector ordered by priority: index 3 (MEM) wins over everything below it.
  logic [3:0] w_req;
  logic [3:0] w_win;
  logic [5:0] w_cause_mask [4];
  logic [5:0] w_stall_run;

  assign w_req = {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cause
      if (gi == 3) begin : g_top
        assign w_win[gi] = w_req[gi];
      end else begin : g_lower
        assign w_win[gi] = w_req[gi] & ~(|w_req[3:gi+1]);
      end
      // Cause gi holds stages 0..gi+1, so the stage behind it takes a bubble.
      assign w_cause_mask[gi] = {6{w_win[gi]}} & 6'((1 << (gi + 2)) - 1);
    end
  endgenerate

  assign w_stall_run = w_cause_mask[0] | w_cause_mask[1] | w_cause_mask[2] | w_cause_mask[3];

  always_comb begin
    w_state_next  = r_state;
    stall         = 6'b000000;
    flush         = 1'b0;
    drain_timeout = 1'b0;
    w_accept      = 1'b0;
    case (r_state)
      ST_RUN: begin
        stall = w_stall_run;
        // An exception under a MEM stall is dropped; MEM re-presents it later.
        if (excp_valid && !stallreq_mem) begin
          w_accept     = 1'b1;
          stall        = 6'b111111;
          w_state_next = ibus_busy ? ST_DRAIN : ST_FLUSH;
        end
      end
      ST_DRAIN: begin
        stall = 6'b111111;
        if (!ibus_busy) begin
          w_state_next = ST_FLUSH;
        end else if (r_drain_cnt == DRAIN_LAST) begin
          drain_timeout = 1'b1;
          w_state_next  = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        flush        = 1'b1;
        w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
    // Outputs are quiet for the whole reset cycle, whatever the current state.
    if (rst) begin
      stall         = 6'b000000;
      flush         = 1'b0;
      drain_timeout = 1'b0;
      w_accept      = 1'b0;
      w_state_next  = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_flush_pc  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_flush_pc <= excp_pc;
      end
      if (r_state == ST_DRAIN && w_state_next == ST_DRAIN) begin
        r_drain_cnt <= r_drain_cnt + 1'b1;
      end else begin
        r_drain_cnt <= '0;
      end
    end
  end

  assign flush_pc = r_flush_pc;

`ifdef PIPE_PERF_CNT_EN
  logic [4:0]       w_perf_inc;
  logic [CNT_W-1:0] w_perf [5];

  assign w_perf_inc[3:0] = (r_state == ST_RUN) ? w_win : 4'b0000;
  assign w_perf_inc[4]   = (r_state == ST_FLUSH);

  generate
    for (gi = 0; gi < 5; gi++) begin : g_perf
      logic [CNT_W-1:0] r_cnt;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (w_perf_inc[gi] && (r_cnt != {CNT_W{1'b1}})) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      assign w_perf[gi] = r_cnt;
    end
  endgenerate

  assign perf_stall_if  = w_perf[0];
  assign perf_stall_id  = w_perf[1];
  assign perf_stall_ex  = w_perf[2];
  assign perf_stall_mem = w_perf[3];
  assign perf_flush     = w_perf[4];
`else
  assign perf_stall_if  = '0;
  assign perf_stall_id  = '0;
  assign perf_stall_ex  = '0;
  assign perf_stall_mem = '0;
  assign perf_flush     = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: stall priority, flush sequencing, drain/timeout, reset.
// Counter expectations follow PIPE_PERF_CNT_EN (zero when the feature is compiled out).
`timescale 1ns/1ps
module tb_pipe_stall_ctrl;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        excp_valid;
  logic [31:0] excp_pc;
  logic        ibus_busy;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        drain_timeout;
  logic [31:0] perf_stall_if, perf_stall_id, perf_stall_ex, perf_stall_mem, perf_flush;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stall_ctrl #(.ADDR_W(32), .DRAIN_MAX(64), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_if   (stallreq_if),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .excp_valid    (excp_valid),
    .excp_pc       (excp_pc),
    .ibus_busy     (ibus_busy),
    .stall         (stall),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .drain_timeout (drain_timeout),
    .perf_stall_if (perf_stall_if),
    .perf_stall_id (perf_stall_id),
    .perf_stall_ex (perf_stall_ex),
    .perf_stall_mem(perf_stall_mem),
    .perf_flush    (perf_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks happen after settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [63:0] pexp(input int n);
    return PERF ? 64'(n) : 64'd0;
  endfunction

  initial begin
    rst = 1'b1;
    {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = 4'b0000;
    excp_valid = 1'b0;
    excp_pc    = 32'h0;
    ibus_busy  = 1'b0;
    step(); step(); step();

    // Reset state and request masking while rst is high
    settle();
    check("rst_stall", stall, 6'b000000);
    check("rst_flush", flush, 1'b0);
    check("rst_flush_pc", flush_pc, 32'h0);
    check("rst_timeout", drain_timeout, 1'b0);
    check("rst_perf_flush", perf_flush, 64'd0);
    stallreq_id = 1'b1;
    settle();
    check("rst_id_masked", stall, 6'b000000);
    step();
    check("rst_id_masked2", stall, 6'b000000);
    rst = 1'b0;
    settle();
    check("id_stall", stall, 6'b000111);
    step();
    stallreq_id = 1'b0;
    settle();
    check("idle_stall", stall, 6'b000000);

    // Priority: mem > ex > if
    {stallreq_if, stallreq_ex, stallreq_mem} = 3'b111;
    settle();
    check("prio_mem", stall, 6'b011111);
    step();
    stallreq_mem = 1'b0;
    settle();
    check("prio_ex", stall, 6'b001111);
    step();
    stallreq_ex = 1'b0;
    settle();
    check("prio_if", stall, 6'b000011);
    step();
    stallreq_if = 1'b0;
    settle();
    check("prio_none", stall, 6'b000000);
    check("perf_mem_1", perf_stall_mem, pexp(1));
    check("perf_ex_1", perf_stall_ex, pexp(1));
    check("perf_if_1", perf_stall_if, pexp(1));
    check("perf_id_1", perf_stall_id, pexp(1));

    // Exception with idle instruction bus: flush the following cycle
    excp_valid = 1'b1;
    excp_pc    = 32'hBFC00380;
    settle();
    check("exc0_stall", stall, 6'b111111);
    check("exc0_flush", flush, 1'b0);
    step();
    excp_valid = 1'b0;
    settle();
    check("exc0_flush_n1", flush, 1'b1);
    check("exc0_stall_n1", stall, 6'b000000);
    check("exc0_pc_n1", flush_pc, 32'hBFC00380);
    step();
    check("exc0_flush_n2", flush, 1'b0);
    check("exc0_pc_hold", flush_pc, 32'hBFC00380);
    check("perf_flush_1", perf_flush, pexp(1));
    stallreq_id = 1'b1;
    settle();
    check("exc0_run_again", stall, 6'b000111);
    stallreq_id = 1'b0;
    settle();

    // Exception while ibus busy for 5 cycles: 6 frozen cycles, then flush
    excp_valid = 1'b1;
    excp_pc    = 32'h80001000;
    ibus_busy  = 1'b1;
    settle();
    check("exc1_stall_n0", stall, 6'b111111);
    for (int k = 1; k <= 5; k++) begin
      step();
      excp_valid = 1'b0;
      ibus_busy  = (k < 5);
      settle();
      check($sformatf("exc1_stall_n%0d", k), stall, 6'b111111);
      check($sformatf("exc1_flush_n%0d", k), flush, 1'b0);
      check($sformatf("exc1_tmo_n%0d", k), drain_timeout, 1'b0);
    end
    step();
    check("exc1_flush", flush, 1'b1);
    check("exc1_pc", flush_pc, 32'h80001000);
    check("exc1_flush_stall", stall, 6'b000000);
    step();
    check("exc1_flush_end", flush, 1'b0);
    check("perf_flush_2", perf_flush, pexp(2));

    // Drain timeout: ibus never drains, pulse on the 64th DRAIN cycle
    excp_valid = 1'b1;
    excp_pc    = 32'h12345678;
    ibus_busy  = 1'b1;
    settle();
    check("tmo_accept", stall, 6'b111111);
    for (int k = 1; k <= 64; k++) begin
      step();
      excp_valid = 1'b0;
      settle();
      check($sformatf("tmo_pulse_n%0d", k), drain_timeout, (k == 64));
      check($sformatf("tmo_flush_n%0d", k), flush, 1'b0);
    end
    step();
    check("tmo_flush", flush, 1'b1);
    check("tmo_pulse_gone", drain_timeout, 1'b0);
    check("tmo_pc", flush_pc, 32'h12345678);
    step();
    check("tmo_flush_end", flush, 1'b0);
    stallreq_id = 1'b1;
    settle();
    check("tmo_run_again", stall, 6'b000111);
    stallreq_id = 1'b0;
    ibus_busy   = 1'b0;
    settle();
    check("perf_flush_3", perf_flush, pexp(3));

    // Exception masked by MEM stall, accepted once MEM releases
    excp_valid   = 1'b1;
    excp_pc      = 32'hBFC00200;
    stallreq_mem = 1'b1;
    settle();
    check("mask_stall", stall, 6'b011111);
    step();
    check("mask_flush", flush, 1'b0);
    check("mask_stall2", stall, 6'b011111);
    check("mask_pc_kept", flush_pc, 32'h12345678);
    stallreq_mem = 1'b0;
    settle();
    check("mask_accept", stall, 6'b111111);
    step();
    excp_valid = 1'b0;
    settle();
    check("mask_flush_n1", flush, 1'b1);
    check("mask_pc", flush_pc, 32'hBFC00200);
    step();
    check("perf_mem_2", perf_stall_mem, pexp(2));
    check("perf_flush_4", perf_flush, pexp(4));

    // Reset in the middle of DRAIN
    excp_valid = 1'b1;
    excp_pc    = 32'hDEAD0000;
    ibus_busy  = 1'b1;
    step();
    excp_valid = 1'b0;
    settle();
    check("rd_drain", stall, 6'b111111);
    step();
    rst = 1'b1;
    settle();
    check("rd_rst_stall", stall, 6'b000000);
    step();
    rst = 1'b0;
    settle();
    check("rd_run_stall", stall, 6'b000000);
    check("rd_pc_cleared", flush_pc, 32'h0);
    check("rd_perf_cleared", perf_flush, 64'd0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rd_no_flush_%0d", k), flush, 1'b0);
      step();
    end
    stallreq_ex = 1'b1;
    settle();
    check("rd_run_ex", stall, 6'b001111);
    stallreq_ex = 1'b0;
    ibus_busy   = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
